// File: rtl/bram_wnd_reader.sv
// Read side of the greyscale line-buffer ring: counts completed lines by snooping the
// writer, streams WND_ROWS-tall pixel columns left to right, and retires one line per pass.
module bram_wnd_reader #(
    parameter int HRES     = 640,
    parameter int VRES     = 480,
    parameter int NLINES   = 8,
    parameter int WND_ROWS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snoop_wr_en,
    input  logic [12:0]           snoop_wr_addr,
    output logic                  bram_rd_en,
    output logic [12:0]           bram_rd_addr,
    input  logic [15:0]           bram_rd_data,
    output logic [8*WND_ROWS-1:0] col_data,
    output logic                  col_valid,
    input  logic                  col_ready,
    output logic                  col_first,
    output logic                  col_last,
    output logic [9:0]            col_row,
    output logic                  pixel_ack,
    output logic                  busy
);

    localparam int FULL_BRAM = NLINES * HRES;
    localparam int XW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int LW = $clog2(NLINES + 1);
    localparam int KW = (WND_ROWS > 1) ? $clog2(WND_ROWS) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, READ, CAPT, OUT, RETIRE} state_t;
    state_t state, state_nxt;

    logic [LW-1:0] lines_avail;
    logic [12:0]   top_base;
    logic [12:0]   rd_base;
    logic [9:0]    top_row;
    logic [XW-1:0] x;
    logic [KW-1:0] rd_k;
    logic [KW-1:0] cap_k;
    logic          cap_en;
    logic          line_done;
    logic          x_last;
    logic          rd_last;
    logic          unused_hi;

    // Advance a line base by one line inside the ring, without a multiplier.
    function automatic logic [12:0] next_base(input logic [12:0] b);
        logic [13:0] s;
        s = {1'b0, b} + 14'(HRES);
        if (s >= 14'(FULL_BRAM))
            s = s - 14'(FULL_BRAM);
        return s[12:0];
    endfunction

    assign line_done = snoop_wr_en && ((int'(snoop_wr_addr) % HRES) == HRES - 1);
    assign x_last    = (x == XW'(HRES - 1));
    assign rd_last   = (rd_k == KW'(WND_ROWS - 1));
    assign unused_hi = ^bram_rd_data[15:8];
    assign col_row   = top_row;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bram_rd_en   = 1'b0;
        bram_rd_addr = '0;
        col_valid    = 1'b0;
        col_first    = 1'b0;
        col_last     = 1'b0;
        pixel_ack    = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE:   if (lines_avail >= LW'(WND_ROWS)) state_nxt = CHECK;
            CHECK:  state_nxt = (top_row > 10'(VRES - WND_ROWS)) ? RETIRE : READ;
            READ: begin
                bram_rd_en   = 1'b1;
                bram_rd_addr = rd_base + 13'(x);
                if (rd_last) state_nxt = CAPT;
            end
            // Last read word lands here; column is complete one cycle later.
            CAPT:   state_nxt = OUT;
            OUT: begin
                col_valid = 1'b1;
                col_first = (x == '0);
                col_last  = x_last;
                if (col_ready) state_nxt = x_last ? RETIRE : READ;
            end
            RETIRE: begin
                pixel_ack = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lines_avail <= '0;
            top_base    <= '0;
            top_row     <= '0;
            rd_base     <= '0;
            x           <= '0;
            rd_k        <= '0;
            cap_k       <= '0;
            cap_en      <= 1'b0;
            col_data    <= '0;
        end else begin
            if (line_done && !pixel_ack) begin
                if (lines_avail != LW'(NLINES))
                    lines_avail <= lines_avail + LW'(1);
            end else if (!line_done && pixel_ack) begin
                lines_avail <= lines_avail - LW'(1);
            end

            cap_en <= bram_rd_en;
            cap_k  <= rd_k;
            if (cap_en) begin
                for (int unsigned k = 0; k < WND_ROWS; k++)
                    if (cap_k == KW'(k)) col_data[8*k +: 8] <= bram_rd_data[7:0];
            end

            case (state)
                CHECK: begin
                    x       <= '0;
                    rd_base <= top_base;
                    rd_k    <= '0;
                end
                READ: begin
                    rd_k    <= rd_k + KW'(1);
                    rd_base <= next_base(rd_base);
                end
                OUT: begin
                    if (col_ready && !x_last) begin
                        x       <= x + XW'(1);
                        rd_base <= top_base;
                        rd_k    <= '0;
                    end
                end
                RETIRE: begin
                    top_base <= next_base(top_base);
                    top_row  <= (top_row == 10'(VRES - 1)) ? 10'd0 : top_row + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
